// File: rtl/ntru_axis_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ntru_axis_bridge_pkg
// Description : Shared modulus encodings, mask width helper and input FSM type
//               for the NTRU AXI-stream bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package ntru_axis_bridge_pkg;

  localparam logic [1:0] c_Q_2048     = 2'd0;
  localparam logic [1:0] c_Q_4096     = 2'd1;
  localparam logic [1:0] c_Q_8192     = 2'd2;
  localparam logic [1:0] c_Q_8192_ALT = 2'd3;

  typedef enum logic [1:0] {
    IN_IDLE   = 2'd0,
    IN_UNPACK = 2'd1,
    IN_WAIT   = 2'd2
  } in_state_e;

  // Number of significant coefficient bits kept for a given modulus select.
  function automatic logic [3:0] mask_bits(input logic [1:0] q);
    mask_bits = 4'd13;
    case (q)
      c_Q_2048:     mask_bits = 4'd11;
      c_Q_4096:     mask_bits = 4'd12;
      c_Q_8192:     mask_bits = 4'd13;
      c_Q_8192_ALT: mask_bits = 4'd13;
      default:      mask_bits = 4'd13;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ntru_lane_packer.sv
`default_nettype none
// ============================================================================
// Module      : ntru_lane_packer
// Description : Collects serial core results into lanes of an AXI-stream beat.
// Revision    : 1.0 - initial release
// ============================================================================
module ntru_lane_packer
  import ntru_axis_bridge_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = 2,
  parameter int COEF_W = 13,
  parameter int N_W    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_run,
  input  logic [N_W-1:0]    i_n,
  input  logic [1:0]        i_q,
  input  logic [COEF_W-1:0] i_coef,
  input  logic              i_coef_valid,
  output logic              o_coef_ready,
  output logic [DATA_W-1:0] o_tdata,
  output logic              o_tvalid,
  output logic              o_tlast,
  input  logic              i_tready
);

  localparam int c_LANE_W = DATA_W / LANES;
  localparam int c_IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;

  logic [DATA_W-1:0]  r_acc;
  logic [DATA_W-1:0]  r_tdata;
  logic [c_IDX_W-1:0] r_lane;
  logic [N_W-1:0]     r_cnt;
  logic               r_pend;
  logic               r_tlast;

  logic [DATA_W-1:0]  w_acc_nxt;
  logic [N_W-1:0]     w_cnt_nxt;
  logic [COEF_W-1:0]  w_mask;
  logic               w_fire;
  logic               w_last_coef;
  logic               w_beat_full;

  assign w_mask       = ~({COEF_W{1'b1}} << mask_bits(i_q));
  assign o_coef_ready = i_run & ~r_pend;
  assign w_fire       = i_coef_valid & o_coef_ready;
  assign w_cnt_nxt    = r_cnt + N_W'(1);
  assign w_last_coef  = (w_cnt_nxt == i_n);
  assign w_beat_full  = (r_lane == c_IDX_W'(LANES - 1));

  assign o_tdata  = r_tdata;
  assign o_tvalid = r_pend;
  assign o_tlast  = r_tlast;

  always_comb begin
    w_acc_nxt = r_acc;
    for (int i = 0; i < LANES; i++) begin
      if (r_lane == c_IDX_W'(i)) begin
        w_acc_nxt[i*c_LANE_W +: c_LANE_W] = c_LANE_W'(i_coef & w_mask);
      end
    end
  end

  // Accumulator is cleared whenever a beat is handed off, so unused lanes stay zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_tdata <= '0;
      r_lane  <= '0;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_tlast <= 1'b0;
    end else begin
      if (w_fire) begin
        r_cnt <= w_cnt_nxt;
        if (w_beat_full || w_last_coef) begin
          r_tdata <= w_acc_nxt;
          r_tlast <= w_last_coef;
          r_pend  <= 1'b1;
          r_acc   <= '0;
          r_lane  <= '0;
        end else begin
          r_acc  <= w_acc_nxt;
          r_lane <= r_lane + c_IDX_W'(1);
        end
      end
      if (r_pend && i_tready) begin
        r_pend  <= 1'b0;
        r_tlast <= 1'b0;
        if (r_tlast) begin
          r_cnt <= '0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ntru_axis_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ntru_axis_bridge
// Description : Unpacks AXI-stream beats into serial NTRU core coefficients and
//               packs serial core results back into AXI-stream beats.
// Revision    : 1.0 - initial release
// ============================================================================
module ntru_axis_bridge
  import ntru_axis_bridge_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LANES   = 2,
  parameter int COEF_W  = 13,
  parameter int SMALL_W = 2,
  parameter int N_W     = 10
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [DATA_W-1:0]  S_AXIS_MM2S_tdata,
  input  logic               S_AXIS_MM2S_tvalid,
  output logic               S_AXIS_MM2S_tready,
  output logic [DATA_W-1:0]  M_AXIS_MM2S_tdata,
  output logic               M_AXIS_MM2S_tvalid,
  input  logic               M_AXIS_MM2S_tready,
  output logic               M_AXIS_MM2S_tlast,
  input  logic [N_W-1:0]     poly_n,
  input  logic [1:0]         poly_q,
  output logic [COEF_W-1:0]  core_in_poly_1,
  output logic [SMALL_W-1:0] core_in_poly_2,
  output logic               core_in_valid,
  input  logic               core_in_ready,
  input  logic [COEF_W-1:0]  core_out,
  input  logic               core_out_valid,
  output logic               core_out_ready,
  output logic               cfg_err
);

  localparam int c_LANE_W = DATA_W / LANES;
  localparam int c_USED_W = COEF_W + SMALL_W;
  localparam int c_IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;

  in_state_e          r_state;
  in_state_e          w_state_nxt;
  logic               r_run;
  logic [DATA_W-1:0]  r_beat;
  logic [c_IDX_W-1:0] r_lane;
  logic [N_W-1:0]     r_in_cnt;
  logic [N_W-1:0]     r_n;
  logic [1:0]         r_q;
  logic               r_cfg_err;

  logic [c_USED_W-1:0] w_lane_bits;
  logic [COEF_W-1:0]   w_mask;
  logic [N_W-1:0]      w_in_cnt_nxt;
  logic                w_in_fire;
  logic                w_cin_fire;
  logic                w_first;
  logic                w_bad_cfg;
  logic                w_lane_last;
  logic                w_in_done;
  logic                w_tlast_fire;
  logic                w_unused_beat;

  assign w_mask        = ~({COEF_W{1'b1}} << mask_bits(r_q));
  assign w_in_fire     = S_AXIS_MM2S_tvalid & S_AXIS_MM2S_tready;
  assign w_cin_fire    = core_in_valid & core_in_ready;
  assign w_first       = (r_in_cnt == '0);
  assign w_bad_cfg     = w_first && (poly_n == '0);
  assign w_in_cnt_nxt  = r_in_cnt + N_W'(1);
  assign w_lane_last   = (r_lane == c_IDX_W'(LANES - 1));
  assign w_in_done     = (w_in_cnt_nxt == r_n);
  assign w_tlast_fire  = M_AXIS_MM2S_tvalid & M_AXIS_MM2S_tready & M_AXIS_MM2S_tlast;
  assign cfg_err       = r_cfg_err;
  // Bits above the small field of each lane carry no information.
  assign w_unused_beat = ^r_beat;

  always_comb begin
    w_lane_bits = '0;
    for (int i = 0; i < LANES; i++) begin
      if (r_lane == c_IDX_W'(i)) begin
        w_lane_bits = r_beat[i*c_LANE_W +: c_USED_W];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IN_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IN_IDLE: begin
        if (w_in_fire && !w_bad_cfg) w_state_nxt = IN_UNPACK;
      end
      IN_UNPACK: begin
        if (w_cin_fire) begin
          if (w_in_done)        w_state_nxt = IN_WAIT;
          else if (w_lane_last) w_state_nxt = IN_IDLE;
        end
      end
      IN_WAIT: begin
        if (w_tlast_fire) w_state_nxt = IN_IDLE;
      end
      default: w_state_nxt = IN_IDLE;
    endcase
  end

  always_comb begin
    S_AXIS_MM2S_tready = r_run && (r_state == IN_IDLE);
    core_in_valid      = (r_state == IN_UNPACK);
    core_in_poly_1     = '0;
    core_in_poly_2     = '0;
    if (r_state == IN_UNPACK) begin
      core_in_poly_1 = w_lane_bits[COEF_W-1:0] & w_mask;
      core_in_poly_2 = w_lane_bits[c_USED_W-1:COEF_W];
    end
  end

  // Frame parameters are only sampled while the input counter is at zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_run     <= 1'b0;
      r_beat    <= '0;
      r_lane    <= '0;
      r_in_cnt  <= '0;
      r_n       <= '0;
      r_q       <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_in_fire) begin
        if (w_first) begin
          r_n <= poly_n;
          r_q <= poly_q;
        end
        if (w_bad_cfg) r_cfg_err <= 1'b1;
        else           r_beat    <= S_AXIS_MM2S_tdata;
      end
      if (w_cin_fire) begin
        r_in_cnt <= w_in_cnt_nxt;
        r_lane   <= (w_lane_last || w_in_done) ? '0 : r_lane + c_IDX_W'(1);
      end
      if (w_tlast_fire) begin
        r_in_cnt <= '0;
      end
    end
  end

  ntru_lane_packer #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .COEF_W (COEF_W),
    .N_W    (N_W)
  ) u_packer (
    .clk          (clk),
    .rst_n        (resetn),
    .i_run        (r_run),
    .i_n          (r_n),
    .i_q          (r_q),
    .i_coef       (core_out),
    .i_coef_valid (core_out_valid),
    .o_coef_ready (core_out_ready),
    .o_tdata      (M_AXIS_MM2S_tdata),
    .o_tvalid     (M_AXIS_MM2S_tvalid),
    .o_tlast      (M_AXIS_MM2S_tlast),
    .i_tready     (M_AXIS_MM2S_tready)
  );

endmodule
`default_nettype wire

// File: tb/tb_ntru_axis_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ntru_axis_bridge
// Description : Directed self-checking bench for ntru_axis_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ntru_axis_bridge;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic [9:0]  poly_n = '0;
  logic [1:0]  poly_q = '0;
  logic [12:0] core_in_poly_1;
  logic [1:0]  core_in_poly_2;
  logic        core_in_valid;
  logic        core_in_ready = 1'b0;
  logic [12:0] core_out = '0;
  logic        core_out_valid = 1'b0;
  logic        core_out_ready;
  logic        cfg_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ntru_axis_bridge #(
    .DATA_W (32), .LANES (2), .COEF_W (13), .SMALL_W (2), .N_W (10)
  ) dut (
    .clk                (clk),
    .resetn             (resetn),
    .S_AXIS_MM2S_tdata  (s_tdata),
    .S_AXIS_MM2S_tvalid (s_tvalid),
    .S_AXIS_MM2S_tready (s_tready),
    .M_AXIS_MM2S_tdata  (m_tdata),
    .M_AXIS_MM2S_tvalid (m_tvalid),
    .M_AXIS_MM2S_tready (m_tready),
    .M_AXIS_MM2S_tlast  (m_tlast),
    .poly_n             (poly_n),
    .poly_q             (poly_q),
    .core_in_poly_1     (core_in_poly_1),
    .core_in_poly_2     (core_in_poly_2),
    .core_in_valid      (core_in_valid),
    .core_in_ready      (core_in_ready),
    .core_out           (core_out),
    .core_out_valid     (core_out_valid),
    .core_out_ready     (core_out_ready),
    .cfg_err            (cfg_err)
  );

  // ---------------- bus drivers (no checking here) ----------------
  task automatic drv_beat(input logic [31:0] d, input logic [9:0] n, input logic [1:0] q, output bit ok);
    bit acc;
    ok = 1'b0;
    s_tdata = d; poly_n = n; poly_q = q; s_tvalid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      acc = s_tready;
      @(posedge clk); #1;
      ok = acc;
    end
    s_tvalid = 1'b0;
  endtask

  task automatic get_core_in(output logic [12:0] p1, output logic [1:0] p2, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (core_in_valid === 1'b1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    p1 = core_in_poly_1; p2 = core_in_poly_2;
    if (ok) begin
      core_in_ready = 1'b1;
      @(posedge clk); #1;
      core_in_ready = 1'b0;
    end
  endtask

  task automatic drv_core_out(input logic [12:0] v, output bit ok);
    bit acc;
    ok = 1'b0;
    core_out = v; core_out_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      acc = core_out_ready;
      @(posedge clk); #1;
      ok = acc;
    end
    core_out_valid = 1'b0;
  endtask

  task automatic get_out(output logic [31:0] d, output logic last, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (m_tvalid === 1'b1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    d = m_tdata; last = m_tlast;
    if (ok) begin
      m_tready = 1'b1;
      @(posedge clk); #1;
      m_tready = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    resetn = 1'b1;
    #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (s_tready !== 1'b0) begin n_bad++; $display("FAIL rst_tready got=%b want=0", s_tready); end
    n_cmp++; if (core_out_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cout_ready got=%b want=0", core_out_ready); end
    n_cmp++; if ({m_tvalid, m_tlast, m_tdata} !== 34'h0) begin n_bad++; $display("FAIL rst_maxis got=%b%b_%h want=00_00000000", m_tvalid, m_tlast, m_tdata); end
    n_cmp++; if ({core_in_valid, core_in_poly_1, core_in_poly_2, cfg_err} !== 17'h0) begin n_bad++; $display("FAIL rst_core got=%b_%h_%h_%b want=0_0000_0_0", core_in_valid, core_in_poly_1, core_in_poly_2, cfg_err); end
    resetn = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (s_tready !== 1'b1) begin n_bad++; $display("FAIL rel_tready got=%b want=1", s_tready); end
    n_cmp++; if (core_out_ready !== 1'b1) begin n_bad++; $display("FAIL rel_cout_ready got=%b want=1", core_out_ready); end
  endtask

  task automatic test_unpack_pack();
    bit ok; logic [12:0] p1; logic [1:0] p2; logic [31:0] d; logic last; int seen;
    drv_beat(32'h4ABC_5FFF, 10'd3, 2'd2, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL up_beat0 got=timeout want=accepted"); end
    n_cmp++; if ({core_in_valid, s_tready} !== 2'b10) begin n_bad++; $display("FAIL up_valid_next got=%b%b want=10", core_in_valid, s_tready); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({core_in_valid, core_in_poly_1, core_in_poly_2} !== {1'b1, 13'h1FFF, 2'd2}) begin n_bad++; $display("FAIL up_hold got=%b_%h_%h want=1_1fff_2", core_in_valid, core_in_poly_1, core_in_poly_2); end
    get_core_in(p1, p2, ok);
    n_cmp++; if ({ok, p1, p2} !== {1'b1, 13'h1FFF, 2'd2}) begin n_bad++; $display("FAIL up_c0 got=%b_%h_%h want=1_1fff_2", ok, p1, p2); end
    get_core_in(p1, p2, ok);
    n_cmp++; if ({ok, p1, p2} !== {1'b1, 13'h0ABC, 2'd2}) begin n_bad++; $display("FAIL up_c1 got=%b_%h_%h want=1_0abc_2", ok, p1, p2); end
    drv_beat(32'h0000_2001, 10'd0, 2'd0, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL up_beat1 got=timeout want=accepted"); end
    get_core_in(p1, p2, ok);
    n_cmp++; if ({ok, p1, p2} !== {1'b1, 13'h0001, 2'd1}) begin n_bad++; $display("FAIL up_c2 got=%b_%h_%h want=1_0001_1", ok, p1, p2); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (core_in_valid !== 1'b0 || s_tready !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL up_drop_lane got=%0d want=0 cycles with valid/tready", seen); end
    drv_core_out(13'd5, ok);
    drv_core_out(13'd6, ok);
    n_cmp++; if (m_tvalid !== 1'b1) begin n_bad++; $display("FAIL pk_valid_next got=%b want=1", m_tvalid); end
    get_out(d, last, ok);
    n_cmp++; if ({ok, last, d} !== {2'b10, 32'h0006_0005}) begin n_bad++; $display("FAIL pk_beat0 got=%b%b_%h want=10_00060005", ok, last, d); end
    drv_core_out(13'd7, ok);
    get_out(d, last, ok);
    n_cmp++; if ({ok, last, d} !== {2'b11, 32'h0000_0007}) begin n_bad++; $display("FAIL pk_beat1 got=%b%b_%h want=11_00000007", ok, last, d); end
    n_cmp++; if (s_tready !== 1'b1) begin n_bad++; $display("FAIL pk_idle got=%b want=1", s_tready); end
  endtask

  task automatic test_mask_q0();
    bit ok; logic [12:0] p1; logic [1:0] p2; logic [31:0] d; logic last;
    drv_beat(32'h1FFF_1FFF, 10'd2, 2'd0, ok);
    get_core_in(p1, p2, ok);
    n_cmp++; if ({ok, p1, p2} !== {1'b1, 13'h07FF, 2'd0}) begin n_bad++; $display("FAIL q0_in0 got=%b_%h_%h want=1_07ff_0", ok, p1, p2); end
    get_core_in(p1, p2, ok);
    drv_core_out(13'h1FFF, ok);
    drv_core_out(13'h0123, ok);
    get_out(d, last, ok);
    n_cmp++; if ({ok, last, d} !== {2'b11, 32'h0123_07FF}) begin n_bad++; $display("FAIL q0_out got=%b%b_%h want=11_012307ff", ok, last, d); end
  endtask

  task automatic test_q3_single();
    bit ok; logic [12:0] p1; logic [1:0] p2; logic [31:0] d; logic last;
    drv_beat(32'hFFFF_FFFF, 10'd1, 2'd3, ok);
    get_core_in(p1, p2, ok);
    n_cmp++; if ({ok, p1, p2} !== {1'b1, 13'h1FFF, 2'd3}) begin n_bad++; $display("FAIL q3_in got=%b_%h_%h want=1_1fff_3", ok, p1, p2); end
    @(posedge clk); #1;
    n_cmp++; if (core_in_valid !== 1'b0) begin n_bad++; $display("FAIL q3_drop got=%b want=0", core_in_valid); end
    drv_core_out(13'h1FFF, ok);
    get_out(d, last, ok);
    n_cmp++; if ({ok, last, d} !== {2'b11, 32'h0000_1FFF}) begin n_bad++; $display("FAIL q3_out got=%b%b_%h want=11_00001fff", ok, last, d); end
  endtask

  task automatic test_stall();
    bit ok; logic [12:0] p1; logic [1:0] p2; logic [31:0] d; logic last; int bad_hold, bad_rdy;
    drv_beat(32'h0002_0001, 10'd4, 2'd2, ok);
    get_core_in(p1, p2, ok);
    get_core_in(p1, p2, ok);
    drv_beat(32'h0004_0003, 10'd4, 2'd2, ok);
    get_core_in(p1, p2, ok);
    get_core_in(p1, p2, ok);
    n_cmp++; if ({ok, p1, p2} !== {1'b1, 13'h0004, 2'd0}) begin n_bad++; $display("FAIL st_in3 got=%b_%h_%h want=1_0004_0", ok, p1, p2); end
    drv_core_out(13'h0AAA, ok);
    drv_core_out(13'h1555, ok);
    core_out = 13'h0123; core_out_valid = 1'b1;
    bad_hold = 0; bad_rdy = 0;
    for (int i = 0; i < 10; i++) begin
      if (m_tvalid !== 1'b1 || m_tdata !== 32'h1555_0AAA || m_tlast !== 1'b0) bad_hold++;
      if (core_out_ready !== 1'b0) bad_rdy++;
      @(posedge clk); #1;
    end
    n_cmp++; if (bad_hold != 0) begin n_bad++; $display("FAIL st_hold got=%0d want=0 unstable cycles", bad_hold); end
    n_cmp++; if (bad_rdy != 0) begin n_bad++; $display("FAIL st_cout_ready got=%0d want=0 ready cycles", bad_rdy); end
    get_out(d, last, ok);
    n_cmp++; if ({ok, last, d} !== {2'b10, 32'h1555_0AAA}) begin n_bad++; $display("FAIL st_beat0 got=%b%b_%h want=10_15550aaa", ok, last, d); end
    drv_core_out(13'h0123, ok);
    drv_core_out(13'h0FED, ok);
    get_out(d, last, ok);
    n_cmp++; if ({ok, last, d} !== {2'b11, 32'h0FED_0123}) begin n_bad++; $display("FAIL st_beat1 got=%b%b_%h want=11_0fed0123", ok, last, d); end
  endtask

  task automatic test_cfg_err();
    bit ok; int seen;
    drv_beat(32'h1234_5678, 10'd0, 2'd2, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL ce_beat got=timeout want=accepted"); end
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (core_in_valid !== 1'b0 || s_tready !== 1'b1) seen++;
      @(posedge clk); #1;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL ce_idle got=%0d want=0 bad cycles", seen); end
    n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL ce_flag got=%b want=1", cfg_err); end
  endtask

  task automatic test_mid_reset();
    bit ok; logic [12:0] p1; logic [1:0] p2; logic [31:0] d; logic last;
    drv_beat(32'h0003_0002, 10'd3, 2'd2, ok);
    get_core_in(p1, p2, ok);
    drv_core_out(13'h0011, ok);
    drv_core_out(13'h0022, ok);
    #2 resetn = 1'b0;
    #1;
    n_cmp++; if ({s_tready, core_out_ready, cfg_err} !== 3'b000) begin n_bad++; $display("FAIL mr_ctrl got=%b%b%b want=000", s_tready, core_out_ready, cfg_err); end
    n_cmp++; if ({m_tvalid, m_tlast, m_tdata} !== 34'h0) begin n_bad++; $display("FAIL mr_maxis got=%b%b_%h want=00_00000000", m_tvalid, m_tlast, m_tdata); end
    n_cmp++; if ({core_in_valid, core_in_poly_1, core_in_poly_2} !== 16'h0) begin n_bad++; $display("FAIL mr_core got=%b_%h_%h want=0_0000_0", core_in_valid, core_in_poly_1, core_in_poly_2); end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (s_tready !== 1'b1) begin n_bad++; $display("FAIL mr_rel got=%b want=1", s_tready); end
    drv_beat(32'h3FFF_2ABC, 10'd2, 2'd1, ok);
    get_core_in(p1, p2, ok);
    n_cmp++; if ({ok, p1, p2} !== {1'b1, 13'h0ABC, 2'd1}) begin n_bad++; $display("FAIL mr_in0 got=%b_%h_%h want=1_0abc_1", ok, p1, p2); end
    get_core_in(p1, p2, ok);
    n_cmp++; if ({ok, p1, p2} !== {1'b1, 13'h0FFF, 2'd1}) begin n_bad++; $display("FAIL mr_in1 got=%b_%h_%h want=1_0fff_1", ok, p1, p2); end
    drv_core_out(13'h1234, ok);
    drv_core_out(13'h0FFF, ok);
    get_out(d, last, ok);
    n_cmp++; if ({ok, last, d} !== {2'b11, 32'h0FFF_0234}) begin n_bad++; $display("FAIL mr_out got=%b%b_%h want=11_0fff0234", ok, last, d); end
  endtask

  initial begin
    test_reset();
    test_unpack_pack();
    test_mask_q0();
    test_q3_single();
    test_stall();
    test_cfg_err();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/ntru_axis_bridge.md
NTRU_AXIS_BRIDGE -- requirements
Module: ntru_axis_bridge

Interface
REQ-001 SHALL have parameters, one per line:
- DATA_W, 32, AXI-stream data width.
- LANES, 2, coefficients per stream beat; legal values 1, 2, 4; DATA_W/LANES >= COEF_W+SMALL_W.
- COEF_W, 13, width of a mod-q coefficient.
- SMALL_W, 2, width of a ternary/small coefficient.
- N_W, 10, width of the frame-length input.

REQ-002 SHALL have ports, one per line:
- clk, in, 1, single clock; all logic on rising edge.
- resetn, in, 1, reset, asynchronous and active-low.
- S_AXIS_MM2S_tdata, in, DATA_W, packed input beat.
- S_AXIS_MM2S_tvalid, in, 1, input valid.
- S_AXIS_MM2S_tready, out, 1, input ready.
- M_AXIS_MM2S_tdata, out, DATA_W, packed result beat.
- M_AXIS_MM2S_tvalid, out, 1, output valid.
- M_AXIS_MM2S_tready, in, 1, output ready.
- M_AXIS_MM2S_tlast, out, 1, last beat of frame.
- poly_n, in, N_W, coefficients per frame.
- poly_q, in, 2, modulus select.
- core_in_poly_1, out, COEF_W, serial coefficient to core.
- core_in_poly_2, out, SMALL_W, serial small coefficient to core.
- core_in_valid, out, 1, core input valid.
- core_in_ready, in, 1, core input ready.
- core_out, in, COEF_W, serial result from core.
- core_out_valid, in, 1, core result valid.
- core_out_ready, out, 1, core result ready.
- cfg_err, out, 1, sticky illegal-configuration flag.

Function
REQ-003 SHALL define lane field L = DATA_W/LANES; lane i occupies tdata[i*L +: L]; coefficient = field[COEF_W-1:0]; small = field[COEF_W+SMALL_W-1:COEF_W]; lane 0 is the lowest index.
REQ-004 SHALL latch poly_n and poly_q on the first accepted input beat of a frame; both are ignored for the rest of the frame.
REQ-005 SHALL mask coefficients to B bits, both in and out, with B = 11/12/13 for poly_q = 0/1/2; poly_q = 3 SHALL behave as 2.
REQ-006 Input FSM SHALL have states IN_IDLE, IN_UNPACK, IN_WAIT.
- IN_IDLE: tready = 1; a beat is accepted and captured, then move to IN_UNPACK.
- IN_UNPACK: tready = 0; emit one lane per core handshake, lanes in ascending order; after the last lane go to IN_IDLE, or to IN_WAIT once poly_n coefficients are sent.
- IN_WAIT: tready = 0 until the output beat with tlast is accepted, then go to IN_IDLE.
REQ-007 SHALL make core_in_valid high the cycle after a beat is accepted; it SHALL hold valid and data stable until core_in_ready.
REQ-008 SHALL discard the surplus lanes of the final input beat when poly_n mod LANES != 0; those lanes are never presented to the core.
REQ-009 Output packer SHALL collect core_out into lanes, ascending; core_out_ready = 1 while collecting and 0 while a packed beat is pending.
REQ-010 SHALL assert M_AXIS_MM2S_tvalid the cycle after LANES coefficients are collected, or after coefficient index poly_n-1; unused lanes and upper lane bits SHALL be zero.
REQ-011 SHALL hold M_AXIS tdata, tvalid and tlast stable until tready; tlast SHALL be high only on the beat containing index poly_n-1.
REQ-012 SHALL treat a latched poly_n = 0 as illegal: set cfg_err, drop the beat, stay in IN_IDLE.
- cfg_err clears only on reset.
REQ-013 SHALL use counters of N_W bits that never wrap within a frame; both counters SHALL clear on tlast acceptance.

Reset
REQ-014 On resetn low, asynchronously and at any point mid-frame: FSM to IN_IDLE, counters to 0, partial beats discarded.
- S_AXIS_MM2S_tready = 0 while resetn is low, 1 from the first clk after release.
- M_AXIS_MM2S_tvalid = 0, M_AXIS_MM2S_tlast = 0, M_AXIS_MM2S_tdata = 0.
- core_in_valid = 0, core_in_poly_1 = 0, core_in_poly_2 = 0.
- core_out_ready = 0 while resetn is low, 1 after release.
- cfg_err = 0.

Structure
REQ-015 The shared ntru package SHALL hold the poly_q encodings, the mask-width function and the state typedef.
REQ-016 The output packer SHALL be sub-module ntru_lane_packer; unpacking stays inline.

Verification
REQ-017 LANES=2, poly_q=2, poly_n=3, beats 0x4ABC_5FFF and 0x0000_2001:
- core receives (0x1FFF,2), (0x0ABC,2), (0x0001,1) in that order; the upper lane of beat 2 is dropped.
REQ-018 poly_q=0, core_out 0x1FFF then 0x0123, poly_n=2:
- one beat 0x0123_07FF with tlast=1.
REQ-019 poly_n=3, core_out 5, 6, 7:
- beats 0x0006_0005 (tlast=0), then 0x0000_0007 (tlast=1).
REQ-020 M_AXIS_MM2S_tready held low for 10 cycles:
- tdata and tvalid stable throughout; core_out_ready = 0; no coefficient lost.
REQ-021 poly_n=0 with one beat:
- cfg_err = 1, no core_in_valid, tready stays 1.
REQ-022 resetn pulsed low mid-frame:
- all outputs at reset values immediately; the next frame of poly_n=2 completes correctly.
